// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station: buffers dispatched ops, wakes operands from writeback, issues the lowest ready entry
module alu_reservation_station #(
  parameter int DATA_LEN     = 32,
  parameter int RRF_SEL      = 6,
  parameter int ALU_OP_WIDTH = 4,
  parameter int ENTRIES      = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      kill_i,
  input  logic                      dispatch_valid_i,
  output logic                      dispatch_ready_o,
  input  logic [ALU_OP_WIDTH-1:0]   dispatch_alu_op_i,
  input  logic [DATA_LEN-1:0]       dispatch_src1_i,
  input  logic [DATA_LEN-1:0]       dispatch_src2_i,
  input  logic                      dispatch_src1_valid_i,
  input  logic                      dispatch_src2_valid_i,
  input  logic [RRF_SEL-1:0]        dispatch_rrf_tag_i,
  input  logic                      dispatch_if_write_rrf_i,
  input  logic                      wb_rrf_we_i,
  input  logic [RRF_SEL-1:0]        wb_rrf_tag_i,
  input  logic [DATA_LEN-1:0]       wb_result_i,
  output logic                      issue_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_LEN-1:0]       src1_o,
  output logic [DATA_LEN-1:0]       src2_o,
  output logic [RRF_SEL-1:0]        rrf_tag_o,
  output logic                      if_write_rrf_o,
  output logic [$clog2(ENTRIES):0]  busy_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  // Per-entry storage; an invalid source holds its producer tag in the low RRF_SEL bits
  logic [ENTRIES-1:0]                   ent_valid_q, ent_valid_d;
  logic [ENTRIES-1:0]                   ent_src1_v_q, ent_src1_v_d;
  logic [ENTRIES-1:0]                   ent_src2_v_q, ent_src2_v_d;
  logic [ENTRIES-1:0]                   ent_wr_q, ent_wr_d;
  logic [ENTRIES-1:0][ALU_OP_WIDTH-1:0] ent_op_q, ent_op_d;
  logic [ENTRIES-1:0][DATA_LEN-1:0]     ent_src1_q, ent_src1_d;
  logic [ENTRIES-1:0][DATA_LEN-1:0]     ent_src2_q, ent_src2_d;
  logic [ENTRIES-1:0][RRF_SEL-1:0]      ent_tag_q, ent_tag_d;

  // Registered issue port
  logic                    issue_q, issue_d;
  logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [DATA_LEN-1:0]     src1_out_q, src1_out_d;
  logic [DATA_LEN-1:0]     src2_out_q, src2_out_d;
  logic [RRF_SEL-1:0]      rrf_tag_q, rrf_tag_d;
  logic                    if_write_rrf_q, if_write_rrf_d;
  logic [CNT_W-1:0]        busy_q, busy_d;

  logic [ENTRIES-1:0] ready;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               dispatch_fire;
  logic               byp1, byp2;

  assign ready            = ent_valid_q & ent_src1_v_q & ent_src2_v_q;
  assign dispatch_ready_o = (busy_q != CNT_W'(ENTRIES));
  assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o && !kill_i;
  assign byp1 = !dispatch_src1_valid_i && wb_rrf_we_i && (dispatch_src1_i[RRF_SEL-1:0] == wb_rrf_tag_i);
  assign byp2 = !dispatch_src2_valid_i && wb_rrf_we_i && (dispatch_src2_i[RRF_SEL-1:0] == wb_rrf_tag_i);

  // Priority encoders: lowest ready entry to issue, lowest free entry to allocate
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!ent_valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Entry update: wakeup, clear on issue, allocate on dispatch, flush on kill
  always_comb begin
    ent_valid_d  = ent_valid_q;
    ent_src1_v_d = ent_src1_v_q;
    ent_src2_v_d = ent_src2_v_q;
    ent_wr_d     = ent_wr_q;
    ent_op_d     = ent_op_q;
    ent_src1_d   = ent_src1_q;
    ent_src2_d   = ent_src2_q;
    ent_tag_d    = ent_tag_q;
    if (wb_rrf_we_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (ent_valid_q[i] && !ent_src1_v_q[i] && (ent_src1_q[i][RRF_SEL-1:0] == wb_rrf_tag_i)) begin
          ent_src1_d[i]   = wb_result_i;
          ent_src1_v_d[i] = 1'b1;
        end
        if (ent_valid_q[i] && !ent_src2_v_q[i] && (ent_src2_q[i][RRF_SEL-1:0] == wb_rrf_tag_i)) begin
          ent_src2_d[i]   = wb_result_i;
          ent_src2_v_d[i] = 1'b1;
        end
      end
    end
    if (sel_found) begin
      ent_valid_d[sel_idx] = 1'b0;
    end
    if (dispatch_fire) begin
      ent_valid_d[free_idx]  = 1'b1;
      ent_op_d[free_idx]     = dispatch_alu_op_i;
      ent_src1_d[free_idx]   = byp1 ? wb_result_i : dispatch_src1_i;
      ent_src1_v_d[free_idx] = dispatch_src1_valid_i || byp1;
      ent_src2_d[free_idx]   = byp2 ? wb_result_i : dispatch_src2_i;
      ent_src2_v_d[free_idx] = dispatch_src2_valid_i || byp2;
      ent_tag_d[free_idx]    = dispatch_rrf_tag_i;
      ent_wr_d[free_idx]     = dispatch_if_write_rrf_i;
    end
    if (kill_i) begin
      ent_valid_d = '0;
    end
  end

  // Issue port and occupancy: payload holds its last value when nothing issues
  always_comb begin
    issue_d        = 1'b0;
    alu_op_d       = alu_op_q;
    src1_out_d     = src1_out_q;
    src2_out_d     = src2_out_q;
    rrf_tag_d      = rrf_tag_q;
    if_write_rrf_d = if_write_rrf_q;
    if (sel_found && !kill_i) begin
      issue_d        = 1'b1;
      alu_op_d       = ent_op_q[sel_idx];
      src1_out_d     = ent_src1_q[sel_idx];
      src2_out_d     = ent_src2_q[sel_idx];
      rrf_tag_d      = ent_tag_q[sel_idx];
      if_write_rrf_d = ent_wr_q[sel_idx];
    end
    busy_d = kill_i ? '0 : (busy_q + CNT_W'(dispatch_fire) - CNT_W'(sel_found));
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ent_valid_q    <= '0;
      ent_src1_v_q   <= '0;
      ent_src2_v_q   <= '0;
      ent_wr_q       <= '0;
      ent_op_q       <= '0;
      ent_src1_q     <= '0;
      ent_src2_q     <= '0;
      ent_tag_q      <= '0;
      issue_q        <= 1'b0;
      alu_op_q       <= '0;
      src1_out_q     <= '0;
      src2_out_q     <= '0;
      rrf_tag_q      <= '0;
      if_write_rrf_q <= 1'b0;
      busy_q         <= '0;
    end else begin
      ent_valid_q    <= ent_valid_d;
      ent_src1_v_q   <= ent_src1_v_d;
      ent_src2_v_q   <= ent_src2_v_d;
      ent_wr_q       <= ent_wr_d;
      ent_op_q       <= ent_op_d;
      ent_src1_q     <= ent_src1_d;
      ent_src2_q     <= ent_src2_d;
      ent_tag_q      <= ent_tag_d;
      issue_q        <= issue_d;
      alu_op_q       <= alu_op_d;
      src1_out_q     <= src1_out_d;
      src2_out_q     <= src2_out_d;
      rrf_tag_q      <= rrf_tag_d;
      if_write_rrf_q <= if_write_rrf_d;
      busy_q         <= busy_d;
    end
  end

  assign issue_o        = issue_q;
  assign alu_op_o       = alu_op_q;
  assign src1_o         = src1_out_q;
  assign src2_o         = src2_out_q;
  assign rrf_tag_o      = rrf_tag_q;
  assign if_write_rrf_o = if_write_rrf_q;
  assign busy_count_o   = busy_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - self-checking bench for alu_reservation_station
module tb_alu_reservation_station;

  localparam int ENT = 8;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        kill_i;
  logic        dispatch_valid_i;
  logic        dispatch_ready_o;
  logic [3:0]  dispatch_alu_op_i;
  logic [31:0] dispatch_src1_i, dispatch_src2_i;
  logic        dispatch_src1_valid_i, dispatch_src2_valid_i;
  logic [5:0]  dispatch_rrf_tag_i;
  logic        dispatch_if_write_rrf_i;
  logic        wb_rrf_we_i;
  logic [5:0]  wb_rrf_tag_i;
  logic [31:0] wb_result_i;
  logic        issue_o;
  logic [3:0]  alu_op_o;
  logic [31:0] src1_o, src2_o;
  logic [5:0]  rrf_tag_o;
  logic        if_write_rrf_o;
  logic [3:0]  busy_count_o;

  int vectors = 0;
  int errors  = 0;

  alu_reservation_station dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .kill_i(kill_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_alu_op_i(dispatch_alu_op_i),
    .dispatch_src1_i(dispatch_src1_i), .dispatch_src2_i(dispatch_src2_i),
    .dispatch_src1_valid_i(dispatch_src1_valid_i), .dispatch_src2_valid_i(dispatch_src2_valid_i),
    .dispatch_rrf_tag_i(dispatch_rrf_tag_i), .dispatch_if_write_rrf_i(dispatch_if_write_rrf_i),
    .wb_rrf_we_i(wb_rrf_we_i), .wb_rrf_tag_i(wb_rrf_tag_i), .wb_result_i(wb_result_i),
    .issue_o(issue_o), .alu_op_o(alu_op_o), .src1_o(src1_o), .src2_o(src2_o),
    .rrf_tag_o(rrf_tag_o), .if_write_rrf_o(if_write_rrf_o), .busy_count_o(busy_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a bag of instruction slots, each with its own operand state
  typedef struct {
    bit        v;
    bit [3:0]  op;
    bit [31:0] s1;
    bit        s1v;
    bit [31:0] s2;
    bit        s2v;
    bit [5:0]  tag;
    bit        wr;
  } ent_t;

  ent_t      m_ent[ENT];
  bit        exp_issue;
  bit [3:0]  exp_op;
  bit [31:0] exp_s1, exp_s2;
  bit [5:0]  exp_tag;
  bit        exp_wr;
  int        exp_busy;
  bit        exp_ready;

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_ent[i] = '{default: 0};
    exp_issue = 0; exp_op = 0; exp_s1 = 0; exp_s2 = 0; exp_tag = 0; exp_wr = 0;
    exp_busy = 0; exp_ready = 1;
  endtask

  task automatic model_step();
    ent_t nxt[ENT];
    int   sel = -1;
    int   fr  = -1;
    int   cnt = 0;
    for (int i = 0; i < ENT; i++) begin
      nxt[i] = m_ent[i];
      if (m_ent[i].v) cnt++;
      else if (fr < 0) fr = i;
      if (sel < 0 && m_ent[i].v && m_ent[i].s1v && m_ent[i].s2v) sel = i;
    end
    for (int i = 0; i < ENT; i++) begin
      if (m_ent[i].v && wb_rrf_we_i) begin
        if (!m_ent[i].s1v && m_ent[i].s1[5:0] == wb_rrf_tag_i) begin nxt[i].s1 = wb_result_i; nxt[i].s1v = 1; end
        if (!m_ent[i].s2v && m_ent[i].s2[5:0] == wb_rrf_tag_i) begin nxt[i].s2 = wb_result_i; nxt[i].s2v = 1; end
      end
    end
    if (sel >= 0) nxt[sel].v = 0;
    if (dispatch_valid_i && cnt < ENT && !kill_i) begin
      nxt[fr].v   = 1;
      nxt[fr].op  = dispatch_alu_op_i;
      nxt[fr].tag = dispatch_rrf_tag_i;
      nxt[fr].wr  = dispatch_if_write_rrf_i;
      nxt[fr].s1v = dispatch_src1_valid_i;
      nxt[fr].s1  = dispatch_src1_i;
      nxt[fr].s2v = dispatch_src2_valid_i;
      nxt[fr].s2  = dispatch_src2_i;
      if (!dispatch_src1_valid_i && wb_rrf_we_i && dispatch_src1_i[5:0] == wb_rrf_tag_i) begin nxt[fr].s1 = wb_result_i; nxt[fr].s1v = 1; end
      if (!dispatch_src2_valid_i && wb_rrf_we_i && dispatch_src2_i[5:0] == wb_rrf_tag_i) begin nxt[fr].s2 = wb_result_i; nxt[fr].s2v = 1; end
    end
    if (kill_i) begin
      for (int i = 0; i < ENT; i++) nxt[i].v = 0;
      exp_issue = 0;
    end else if (sel >= 0) begin
      exp_issue = 1;
      exp_op = m_ent[sel].op; exp_s1 = m_ent[sel].s1; exp_s2 = m_ent[sel].s2;
      exp_tag = m_ent[sel].tag; exp_wr = m_ent[sel].wr;
    end else begin
      exp_issue = 0;
    end
    exp_busy = 0;
    for (int i = 0; i < ENT; i++) begin
      m_ent[i] = nxt[i];
      if (nxt[i].v) exp_busy++;
    end
    exp_ready = (exp_busy != ENT);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    kill_i = 0; dispatch_valid_i = 0; dispatch_alu_op_i = 0;
    dispatch_src1_i = 0; dispatch_src2_i = 0;
    dispatch_src1_valid_i = 0; dispatch_src2_valid_i = 0;
    dispatch_rrf_tag_i = 0; dispatch_if_write_rrf_i = 0;
    wb_rrf_we_i = 0; wb_rrf_tag_i = 0; wb_result_i = 0;
  endtask

  task automatic drive_dispatch(input bit [3:0] op, input bit [31:0] s1, input bit v1,
                                input bit [31:0] s2, input bit v2, input bit [5:0] tag, input bit wr);
    dispatch_valid_i = 1; dispatch_alu_op_i = op;
    dispatch_src1_i = s1; dispatch_src1_valid_i = v1;
    dispatch_src2_i = s2; dispatch_src2_valid_i = v2;
    dispatch_rrf_tag_i = tag; dispatch_if_write_rrf_i = wr;
  endtask

  task automatic test_reset();
    vectors++; if ({issue_o, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o} !== '0) begin errors++; $display("FAIL reset_outputs: got issue=%0b op=%0h s1=%0h s2=%0h tag=%0h wr=%0b expected all 0", issue_o, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o); end
    vectors++; if (busy_count_o !== 4'd0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy_count_o); end
    vectors++; if (dispatch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", dispatch_ready_o); end
  endtask

  task automatic test_ready_dispatch();
    drive_dispatch(4'h1, 32'd5, 1, 32'd7, 1, 6'd3, 1);
    tick();
    idle_inputs();
    vectors++; if (busy_count_o !== 4'd1) begin errors++; $display("FAIL rd_busy1: got %0d expected 1", busy_count_o); end
    vectors++; if (issue_o !== 1'b0) begin errors++; $display("FAIL rd_no_early_issue: got %0b expected 0", issue_o); end
    tick();
    vectors++; if ({issue_o, src1_o, src2_o, rrf_tag_o, alu_op_o, if_write_rrf_o} !== {1'b1, 32'd5, 32'd7, 6'd3, 4'h1, 1'b1}) begin errors++; $display("FAIL rd_issue: got issue=%0b s1=%0d s2=%0d tag=%0d op=%0h wr=%0b expected 1 5 7 3 1 1", issue_o, src1_o, src2_o, rrf_tag_o, alu_op_o, if_write_rrf_o); end
    vectors++; if (busy_count_o !== 4'd0) begin errors++; $display("FAIL rd_busy0: got %0d expected 0", busy_count_o); end
    tick();
    vectors++; if (issue_o !== 1'b0 || src1_o !== 32'd5) begin errors++; $display("FAIL rd_pulse_hold: got issue=%0b s1=%0d expected 0 and held 5", issue_o, src1_o); end
  endtask

  task automatic test_wakeup();
    drive_dispatch(4'h2, 32'd10, 1, 32'd9, 0, 6'd12, 0);
    tick();
    idle_inputs();
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd8; wb_result_i = 32'hBEEF;
    tick();
    wb_rrf_we_i = 0;
    tick();
    vectors++; if (issue_o !== 1'b0) begin errors++; $display("FAIL wk_nomatch: got issue=%0b expected 0", issue_o); end
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd9; wb_result_i = 32'hDEAD;
    tick();
    wb_rrf_we_i = 0;
    vectors++; if (issue_o !== 1'b0) begin errors++; $display("FAIL wk_capture_edge: got issue=%0b expected 0", issue_o); end
    tick();
    vectors++; if ({issue_o, src1_o, src2_o, rrf_tag_o} !== {1'b1, 32'd10, 32'hDEAD, 6'd12}) begin errors++; $display("FAIL wk_issue: got issue=%0b s1=%0h s2=%0h tag=%0d expected 1 a dead 12", issue_o, src1_o, src2_o, rrf_tag_o); end
  endtask

  task automatic test_bypass();
    drive_dispatch(4'h3, 32'd4, 0, 32'd2, 1, 6'd5, 1);
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd4; wb_result_i = 32'h11;
    tick();
    idle_inputs();
    tick();
    vectors++; if ({issue_o, src1_o, src2_o} !== {1'b1, 32'h11, 32'd2}) begin errors++; $display("FAIL byp_issue: got issue=%0b s1=%0h s2=%0h expected 1 11 2", issue_o, src1_o, src2_o); end
  endtask

  task automatic test_full();
    for (int k = 0; k < ENT; k++) begin
      drive_dispatch(4'(k), 32'd1, 0, 32'(k + 100), 1, 6'(k + 16), 0);
      tick();
    end
    vectors++; if (dispatch_ready_o !== 1'b0 || busy_count_o !== 4'd8) begin errors++; $display("FAIL full_state: got ready=%0b busy=%0d expected 0 8", dispatch_ready_o, busy_count_o); end
    drive_dispatch(4'hF, 32'd0, 1, 32'd0, 1, 6'd63, 0);
    tick();
    idle_inputs();
    vectors++; if (busy_count_o !== 4'd8 || issue_o !== 1'b0) begin errors++; $display("FAIL full_drop: got busy=%0d issue=%0b expected 8 0", busy_count_o, issue_o); end
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd1; wb_result_i = 32'h55;
    tick();
    idle_inputs();
    for (int k = 0; k < ENT; k++) begin
      tick();
      vectors++; if ({issue_o, rrf_tag_o, src1_o, src2_o} !== {1'b1, 6'(k + 16), 32'h55, 32'(k + 100)}) begin errors++; $display("FAIL full_issue_order[%0d]: got issue=%0b tag=%0d s1=%0h s2=%0d expected 1 %0d 55 %0d", k, issue_o, rrf_tag_o, src1_o, src2_o, k + 16, k + 100); end
      vectors++; if (dispatch_ready_o !== 1'b1 || busy_count_o !== 4'(7 - k)) begin errors++; $display("FAIL full_drain[%0d]: got ready=%0b busy=%0d expected 1 %0d", k, dispatch_ready_o, busy_count_o, 7 - k); end
    end
    tick();
    vectors++; if (issue_o !== 1'b0) begin errors++; $display("FAIL full_end: got issue=%0b expected 0", issue_o); end
  endtask

  task automatic test_kill();
    drive_dispatch(4'h1, 32'd20, 0, 32'd1, 1, 6'd1, 1); tick();
    drive_dispatch(4'h2, 32'd2, 1, 32'd20, 0, 6'd2, 1); tick();
    drive_dispatch(4'h3, 32'd20, 0, 32'd20, 0, 6'd3, 1); tick();
    vectors++; if (busy_count_o !== 4'd3) begin errors++; $display("FAIL kill_pre_busy: got %0d expected 3", busy_count_o); end
    drive_dispatch(4'h4, 32'd1, 1, 32'd1, 1, 6'd4, 1);
    kill_i = 1;
    tick();
    idle_inputs();
    vectors++; if (busy_count_o !== 4'd0 || issue_o !== 1'b0 || dispatch_ready_o !== 1'b1) begin errors++; $display("FAIL kill_flush: got busy=%0d issue=%0b ready=%0b expected 0 0 1", busy_count_o, issue_o, dispatch_ready_o); end
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd20; wb_result_i = 32'h77;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (issue_o !== 1'b0 || busy_count_o !== 4'd0) begin errors++; $display("FAIL kill_no_late_issue[%0d]: got issue=%0b busy=%0d expected 0 0", k, issue_o, busy_count_o); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      dispatch_valid_i        = ($urandom_range(0, 99) < 60);
      dispatch_alu_op_i       = 4'($urandom);
      dispatch_src1_valid_i   = 1'($urandom_range(0, 1));
      dispatch_src2_valid_i   = 1'($urandom_range(0, 1));
      dispatch_src1_i         = dispatch_src1_valid_i ? $urandom : {26'($urandom), 6'($urandom_range(0, 7))};
      dispatch_src2_i         = dispatch_src2_valid_i ? $urandom : {26'($urandom), 6'($urandom_range(0, 7))};
      dispatch_rrf_tag_i      = 6'($urandom);
      dispatch_if_write_rrf_i = 1'($urandom_range(0, 1));
      wb_rrf_we_i             = ($urandom_range(0, 99) < 45);
      wb_rrf_tag_i            = 6'($urandom_range(0, 7));
      wb_result_i             = $urandom;
      kill_i                  = ($urandom_range(0, 59) == 0);
      if (n >= 560) idle_inputs();
      tick();
      vectors++; if (issue_o !== exp_issue || busy_count_o !== 4'(exp_busy) || dispatch_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ctrl[%0d]: got issue=%0b busy=%0d ready=%0b expected %0b %0d %0b", n, issue_o, busy_count_o, dispatch_ready_o, exp_issue, exp_busy, exp_ready); end
      if (exp_issue) begin
        vectors++; if ({alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o} !== {exp_op, exp_s1, exp_s2, exp_tag, exp_wr}) begin errors++; $display("FAIL rnd_payload[%0d]: got op=%0h s1=%0h s2=%0h tag=%0h wr=%0b expected %0h %0h %0h %0h %0b", n, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o, exp_op, exp_s1, exp_s2, exp_tag, exp_wr); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_dispatch(4'h5, 32'd30, 0, 32'd3, 1, 6'd9, 1); tick();
    drive_dispatch(4'h6, 32'h12, 1, 32'h34, 1, 6'd10, 1); tick();
    idle_inputs();
    tick();
    vectors++; if (issue_o !== 1'b1 || rrf_tag_o !== 6'd10) begin errors++; $display("FAIL ar_pre_issue: got issue=%0b tag=%0d expected 1 10", issue_o, rrf_tag_o); end
    #2;
    reset_ni = 0;
    #1;
    vectors++; if ({issue_o, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o, busy_count_o} !== '0) begin errors++; $display("FAIL ar_outputs: got issue=%0b op=%0h s1=%0h s2=%0h tag=%0h wr=%0b busy=%0d expected all 0", issue_o, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o, busy_count_o); end
    vectors++; if (dispatch_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready: got %0b expected 1", dispatch_ready_o); end
    #1;
    reset_ni = 1;
    model_reset();
    wb_rrf_we_i = 1; wb_rrf_tag_i = 6'd30; wb_result_i = 32'h99;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (issue_o !== 1'b0 || busy_count_o !== 4'd0) begin errors++; $display("FAIL ar_discarded[%0d]: got issue=%0b busy=%0d expected 0 0", k, issue_o, busy_count_o); end
    end
  endtask

  initial begin
    reset_ni = 0;
    idle_inputs();
    model_reset();
    #3;
    test_reset();
    #9;
    reset_ni = 1;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_full();
    test_kill();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
